// File: rtl/maxpool_scheduler.sv
// 2x2 max-pool window sequencer: fetches each window's four pixels from the feature map,
// hands them to the pooling unit and writes the pooled value to the output map.
module maxpool_scheduler #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 4,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               rd_en,
    output logic [ADDR_W-1:0]  rd_addr,
    input  logic [DATA_W-1:0]  rd_data,
    output logic               pool_en,
    output logic [DATA_W-1:0]  pool_in0,
    output logic [DATA_W-1:0]  pool_in1,
    output logic [DATA_W-1:0]  pool_in2,
    output logic [DATA_W-1:0]  pool_in3,
    input  logic [DATA_W-1:0]  pool_out,
    input  logic               pool_done,
    output logic               wr_en,
    output logic [OADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0]  wr_data,
    output logic [OADDR_W-1:0] win_cnt
);

    localparam int W2 = IMG_W / 2;
    localparam int H2 = IMG_H / 2;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_LAST, S_POOL, S_WRITE} state_t;

    state_t             state_q;
    logic [1:0]         k_q;
    logic [OADDR_W-1:0] wr_q, wc_q;
    logic [TW-1:0]      tmo_q;
    logic               last_q;
    logic               busy_q, done_q, err_q;
    logic               rd_en_q, pool_en_q, wr_en_q;
    logic [ADDR_W-1:0]  rd_addr_q;
    logic [DATA_W-1:0]  pix_q [4];
    logic [OADDR_W-1:0] wr_addr_q, win_cnt_q;
    logic [DATA_W-1:0]  wr_data_q;

    logic [OADDR_W-1:0] wr_d, wc_d;
    logic               last_win;
    logic [1:0]         k_nx;
    logic [ADDR_W-1:0]  base_addr, fetch_off;

    // Window position after the current one, raster order; wraps to (0,0) after the last.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no latch is inferred.
        wc_d     = wc_q + OADDR_W'(1);
        wr_d     = wr_q;
        last_win = 1'b0;
        if (wc_q == OADDR_W'(W2 - 1)) begin
            wc_d = '0;
            if (wr_q == OADDR_W'(H2 - 1)) begin
                wr_d     = '0;
                last_win = 1'b1;
            end else begin
                wr_d = wr_q + OADDR_W'(1);
            end
        end
    end

    assign k_nx      = k_q + 2'd1;
    assign base_addr = ADDR_W'(2 * IMG_W * int'(wr_q) + 2 * int'(wc_q));
    assign fetch_off = ADDR_W'(IMG_W * int'(k_nx[1]) + int'(k_nx[0]));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            wr_q      <= '0;
            wc_q      <= '0;
            tmo_q     <= '0;
            last_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_en_q   <= 1'b0;
            rd_addr_q <= '0;
            pool_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            win_cnt_q <= '0;
            // NOTE: pix_q is four plain registers driving outputs, not a RAM, so it is reset too.
            for (int i = 0; i < 4; i++) pix_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees start-of-cycle state.
            done_q <= 1'b0;
            if (abort) begin
                state_q   <= S_IDLE;
                busy_q    <= 1'b0;
                rd_en_q   <= 1'b0;
                pool_en_q <= 1'b0;
                wr_en_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (start) begin
                            err_q     <= 1'b0;
                            win_cnt_q <= '0;
                            wr_q      <= '0;
                            wc_q      <= '0;
                            k_q       <= '0;
                            busy_q    <= 1'b1;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= '0;
                            state_q   <= S_FETCH;
                        end
                    end
                    S_FETCH: begin
                        // Read k-1 returns its data while read k is being issued.
                        if (k_q != 2'd0) pix_q[k_q - 2'd1] <= rd_data;
                        k_q <= k_nx;
                        if (k_q == 2'd3) begin
                            rd_en_q <= 1'b0;
                            state_q <= S_LAST;
                        end else begin
                            rd_addr_q <= base_addr + fetch_off;
                        end
                    end
                    S_LAST: begin
                        pix_q[3]  <= rd_data;
                        pool_en_q <= 1'b1;
                        tmo_q     <= '0;
                        state_q   <= S_POOL;
                    end
                    S_POOL: begin
                        if (pool_done) begin
                            pool_en_q <= 1'b0;
                            wr_en_q   <= 1'b1;
                            wr_data_q <= pool_out;
                            wr_addr_q <= OADDR_W'(W2 * int'(wr_q) + int'(wc_q));
                            win_cnt_q <= win_cnt_q + OADDR_W'(1);
                            last_q    <= last_win;
                            wr_q      <= wr_d;
                            wc_q      <= wc_d;
                            state_q   <= S_WRITE;
                        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
                            pool_en_q <= 1'b0;
                            err_q     <= 1'b1;
                            done_q    <= 1'b1;
                            busy_q    <= 1'b0;
                            state_q   <= S_IDLE;
                        end else begin
                            tmo_q <= tmo_q + TW'(1);
                        end
                    end
                    S_WRITE: begin
                        wr_en_q <= 1'b0;
                        if (last_q) begin
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end else begin
                            k_q       <= '0;
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_addr;
                            state_q   <= S_FETCH;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign rd_en    = rd_en_q;
    assign rd_addr  = rd_addr_q;
    assign pool_en  = pool_en_q;
    assign pool_in0 = pix_q[0];
    assign pool_in1 = pix_q[1];
    assign pool_in2 = pix_q[2];
    assign pool_in3 = pix_q[3];
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign win_cnt  = win_cnt_q;

endmodule
